idecoder_stage: RTL and testbench

- Registered, flow-controlled RV32I instruction decode stage between fetch and execute; generalises the combinational decoder to the full RV32I base set.
- Adds an illegal-instruction flag, a PC pass-through, valid/ready handshakes on both sides, a 2-entry skid buffer for full throughput, and a synchronous flush for branch/jump redirects.

---
 rtl/idecoder_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_idecoder_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/idecoder_stage.sv
// Registered RV32I decode stage: combinational field decode on the fetch side,
// a 2-entry (or 1-entry) output buffer with valid/ready on both sides and flush.
module idecoder_stage #(
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int IMM_WIDTH  = 32,
  parameter int REG_WIDTH  = 5,
  parameter int SKID       = 1,
  localparam int INST_TYPE_WIDTH = 4,
  localparam int FUNCT_WIDTH     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST_WIDTH-1:0]      in_inst,
  input  logic [PC_WIDTH-1:0]        in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [IMM_WIDTH-1:0]       imm,
  output logic [INST_TYPE_WIDTH-1:0] inst_type,
  output logic [REG_WIDTH-1:0]       rd,
  output logic [REG_WIDTH-1:0]       rs1,
  output logic [REG_WIDTH-1:0]       rs2,
  output logic [FUNCT_WIDTH-1:0]     funct,
  output logic                       illegal
);

  // Instruction class codes; 0 is reserved for illegal instructions.
  localparam logic [INST_TYPE_WIDTH-1:0] T_NONE = 4'd0, T_REG = 4'd1, T_IMM = 4'd2,
    T_LOAD = 4'd3, T_STORE = 4'd4, T_BRANCH = 4'd5, T_JAL = 4'd6, T_JALR = 4'd7,
    T_LUI = 4'd8, T_AUIPC = 4'd9, T_FENCE = 4'd10, T_SYSTEM = 4'd11;

  localparam logic [FUNCT_WIDTH-1:0] F_NONE = 5'd0, F_ADD = 5'd1, F_SUB = 5'd2,
    F_SLL = 5'd3, F_SLT = 5'd4, F_SLTU = 5'd5, F_XOR = 5'd6, F_OR = 5'd7, F_AND = 5'd8,
    F_SRL = 5'd9, F_SRA = 5'd10, F_EQ = 5'd11, F_NEQ = 5'd12, F_LT = 5'd13,
    F_GTE = 5'd14, F_LTU = 5'd15, F_GTEU = 5'd16, F_MEM_BYTE = 5'd17,
    F_MEM_HWORD = 5'd18, F_MEM_WORD = 5'd19, F_MEM_BYTEU = 5'd20, F_MEM_HWORDU = 5'd21;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
    OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
    OP_STORE = 7'b0100011, OP_OPIMM = 7'b0010011, OP_OP = 7'b0110011,
    OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [PC_WIDTH-1:0]        pc;
    logic [IMM_WIDTH-1:0]       imm;
    logic [INST_TYPE_WIDTH-1:0] typ;
    logic [FUNCT_WIDTH-1:0]     fn;
    logic [REG_WIDTH-1:0]       rd;
    logic [REG_WIDTH-1:0]       rs1;
    logic [REG_WIDTH-1:0]       rs2;
    logic                       ill;
  } dec_t;

  function automatic logic [IMM_WIDTH-1:0] sext(input logic signed [31:0] v);
    return IMM_WIDTH'(v);
  endfunction

  function automatic logic [IMM_WIDTH-1:0] zext_shamt(input logic [4:0] s);
    return IMM_WIDTH'(s);
  endfunction

  function automatic logic [FUNCT_WIDTH-1:0] alu_fn(input logic [2:0] f3);
    case (f3)
      3'd0:    return F_ADD;
      3'd1:    return F_SLL;
      3'd2:    return F_SLT;
      3'd3:    return F_SLTU;
      3'd4:    return F_XOR;
      3'd5:    return F_SRL;
      3'd6:    return F_OR;
      default: return F_AND;
    endcase
  endfunction

  function automatic logic [FUNCT_WIDTH-1:0] branch_fn(input logic [2:0] f3);
    case (f3)
      3'd0:    return F_EQ;
      3'd1:    return F_NEQ;
      3'd4:    return F_LT;
      3'd5:    return F_GTE;
      3'd6:    return F_LTU;
      3'd7:    return F_GTEU;
      default: return F_NONE;
    endcase
  endfunction

  function automatic logic [FUNCT_WIDTH-1:0] mem_fn(input logic [2:0] f3);
    case (f3)
      3'd0:    return F_MEM_BYTE;
      3'd1:    return F_MEM_HWORD;
      3'd2:    return F_MEM_WORD;
      3'd4:    return F_MEM_BYTEU;
      3'd5:    return F_MEM_HWORDU;
      default: return F_NONE;
    endcase
  endfunction

  logic [6:0]           opcode;
  logic [2:0]           f3;
  logic [6:0]           f7;
  logic [REG_WIDTH-1:0] f_rd, f_rs1, f_rs2;
  logic [31:0]          imm_i, imm_s, imm_b, imm_u, imm_j;
  logic                 bad;
  dec_t                 dec_p0;
  dec_t                 out_p1, skid_p1;
  logic                 skid_vld_p1;
  logic                 accept;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];
  assign f_rd   = REG_WIDTH'(in_inst[11:7]);
  assign f_rs1  = REG_WIDTH'(in_inst[19:15]);
  assign f_rs2  = REG_WIDTH'(in_inst[24:20]);
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Stage p0: combinational decode of the presented instruction
  always_comb begin
    dec_p0    = '0;
    dec_p0.pc = in_pc;
    bad       = 1'b0;
    case (opcode)
      OP_LUI:   begin dec_p0.typ = T_LUI;   dec_p0.rd = f_rd; dec_p0.imm = sext(imm_u); end
      OP_AUIPC: begin dec_p0.typ = T_AUIPC; dec_p0.rd = f_rd; dec_p0.imm = sext(imm_u); end
      OP_JAL:   begin dec_p0.typ = T_JAL;   dec_p0.rd = f_rd; dec_p0.imm = sext(imm_j); end
      OP_JALR: begin
        dec_p0.typ = T_JALR; dec_p0.fn = F_ADD; dec_p0.rd = f_rd; dec_p0.rs1 = f_rs1;
        dec_p0.imm = sext(imm_i);
        bad = (f3 != 3'd0);
      end
      OP_BRANCH: begin
        dec_p0.typ = T_BRANCH; dec_p0.fn = branch_fn(f3); dec_p0.rs1 = f_rs1; dec_p0.rs2 = f_rs2;
        dec_p0.imm = sext(imm_b);
        bad = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OP_LOAD: begin
        dec_p0.typ = T_LOAD; dec_p0.fn = mem_fn(f3); dec_p0.rd = f_rd; dec_p0.rs1 = f_rs1;
        dec_p0.imm = sext(imm_i);
        bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OP_STORE: begin
        dec_p0.typ = T_STORE; dec_p0.fn = mem_fn(f3); dec_p0.rs1 = f_rs1; dec_p0.rs2 = f_rs2;
        dec_p0.imm = sext(imm_s);
        bad = (f3 > 3'd2);
      end
      OP_OPIMM: begin
        dec_p0.typ = T_IMM; dec_p0.rd = f_rd; dec_p0.rs1 = f_rs1;
        if (f3 == 3'd1) begin
          dec_p0.fn = F_SLL; dec_p0.imm = zext_shamt(in_inst[24:20]);
          bad = (f7 != 7'd0);
        end else if (f3 == 3'd5) begin
          dec_p0.fn = f7[5] ? F_SRA : F_SRL; dec_p0.imm = zext_shamt(in_inst[24:20]);
          bad = (f7 != 7'd0) && (f7 != 7'h20);
        end else begin
          dec_p0.fn = alu_fn(f3); dec_p0.imm = sext(imm_i);
        end
      end
      OP_OP: begin
        dec_p0.typ = T_REG; dec_p0.rd = f_rd; dec_p0.rs1 = f_rs1; dec_p0.rs2 = f_rs2;
        if (f7 == 7'd0)                      dec_p0.fn = alu_fn(f3);
        else if (f7 == 7'h20 && f3 == 3'd0)  dec_p0.fn = F_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5)  dec_p0.fn = F_SRA;
        else                                 bad = 1'b1;
      end
      OP_FENCE: begin
        dec_p0.typ = T_FENCE; dec_p0.rd = f_rd; dec_p0.rs1 = f_rs1; dec_p0.imm = sext(imm_i);
      end
      OP_SYSTEM: begin
        dec_p0.typ = T_SYSTEM; dec_p0.rd = f_rd; dec_p0.rs1 = f_rs1; dec_p0.imm = sext(imm_i);
      end
      default: bad = 1'b1;
    endcase
    // Illegal instructions keep only their PC so the fault can be reported downstream.
    if (bad) begin
      dec_p0     = '0;
      dec_p0.pc  = in_pc;
      dec_p0.ill = 1'b1;
    end
  end

  assign in_ready = (SKID != 0) ? !skid_vld_p1 : (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  // Stage p1: output register plus skid entry, strict FIFO order
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      skid_vld_p1 <= 1'b0;
      out_p1      <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_vld_p1) begin
        out_p1      <= skid_p1;
        out_valid   <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) out_p1 <= dec_p0;
      end
    end else if (accept && SKID != 0) begin
      skid_vld_p1 <= 1'b1;
      skid_p1     <= dec_p0;
    end
  end

  assign out_pc    = out_p1.pc;
  assign imm       = out_p1.imm;
  assign inst_type = out_p1.typ;
  assign funct     = out_p1.fn;
  assign rd        = out_p1.rd;
  assign rs1       = out_p1.rs1;
  assign rs2       = out_p1.rs2;
  assign illegal   = out_p1.ill;

endmodule

// File: tb/tb_idecoder_stage.sv
// Bench for idecoder_stage: directed RV32I cases then random traffic, checked
// against a 2-deep FIFO model with a table-driven reference decoder.
module tb_idecoder_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] in_inst, in_pc, out_pc, imm;
  logic [3:0]  inst_type;
  logic [4:0]  funct, rd, rs1, rs2;

  always #5 clk = ~clk;

  idecoder_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .imm(imm), .inst_type(inst_type), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct(funct), .illegal(illegal)
  );

  localparam logic [3:0] T_REG = 1, T_IMM = 2, T_LOAD = 3, T_STORE = 4, T_BRANCH = 5,
    T_JAL = 6, T_JALR = 7, T_LUI = 8, T_AUIPC = 9, T_FENCE = 10, T_SYSTEM = 11;
  localparam logic [4:0] F_ADD = 1, F_SUB = 2, F_SLL = 3, F_SLT = 4, F_SLTU = 5,
    F_XOR = 6, F_OR = 7, F_AND = 8, F_SRL = 9, F_SRA = 10, F_EQ = 11, F_NEQ = 12,
    F_LT = 13, F_GTE = 14, F_LTU = 15, F_GTEU = 16, F_MB = 17, F_MH = 18, F_MW = 19,
    F_MBU = 20, F_MHU = 21;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  typ;
    logic [4:0]  fn;
    logic [4:0]  rd, rs1, rs2;
    logic        ill;
  } exp_t;

  logic [4:0] alu_tab [8] = '{F_ADD, F_SLL, F_SLT, F_SLTU, F_XOR, F_SRL, F_OR, F_AND};
  logic [4:0] br_tab  [8] = '{F_EQ, F_NEQ, 5'd0, 5'd0, F_LT, F_GTE, F_LTU, F_GTEU};
  logic [4:0] ld_tab  [8] = '{F_MB, F_MH, F_MW, 5'd0, F_MBU, F_MHU, 5'd0, 5'd0};
  logic [6:0] opc_tab [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                               7'h13, 7'h33, 7'h0F, 7'h73};

  exp_t        q[$];
  logic [31:0] seen[$];
  int          checks = 0;
  int          failures = 0;

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill;
    e = '0; f3 = i[14:12]; f7 = i[31:25]; ill = 1'b0;
    case (i[6:0])
      7'h37: begin e.typ = T_LUI;   e.rd = i[11:7]; e.imm = i & 32'hFFFFF000; end
      7'h17: begin e.typ = T_AUIPC; e.rd = i[11:7]; e.imm = i & 32'hFFFFF000; end
      7'h6F: begin
        e.typ = T_JAL; e.rd = i[11:7];
        e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21]})) << 1;
      end
      7'h67: begin
        e.typ = T_JALR; e.fn = F_ADD; e.rd = i[11:7]; e.rs1 = i[19:15];
        e.imm = 32'($signed(i[31:20])); ill = (f3 != 0);
      end
      7'h63: begin
        e.typ = T_BRANCH; e.fn = br_tab[f3]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8]})) << 1;
        ill = (br_tab[f3] == 0);
      end
      7'h03: begin
        e.typ = T_LOAD; e.fn = ld_tab[f3]; e.rd = i[11:7]; e.rs1 = i[19:15];
        e.imm = 32'($signed(i[31:20])); ill = (ld_tab[f3] == 0);
      end
      7'h23: begin
        e.typ = T_STORE; e.fn = F_MB + 5'(f3); e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.imm = 32'($signed({i[31:25], i[11:7]})); ill = (f3 > 2);
      end
      7'h13: begin
        e.typ = T_IMM; e.rd = i[11:7]; e.rs1 = i[19:15]; e.fn = alu_tab[f3];
        if (f3 == 1 || f3 == 5) begin
          e.imm = 32'(i[24:20]);
          if (f7 == 7'd32 && f3 == 5) e.fn = F_SRA;
          else if (f7 != 0) ill = 1'b1;
        end else e.imm = 32'($signed(i[31:20]));
      end
      7'h33: begin
        e.typ = T_REG; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        if (f7 == 0) e.fn = alu_tab[f3];
        else if (f7 == 7'd32 && f3 == 0) e.fn = F_SUB;
        else if (f7 == 7'd32 && f3 == 5) e.fn = F_SRA;
        else ill = 1'b1;
      end
      7'h0F: begin e.typ = T_FENCE;  e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = 32'($signed(i[31:20])); end
      7'h73: begin e.typ = T_SYSTEM; e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = 32'($signed(i[31:20])); end
      default: ill = 1'b1;
    endcase
    if (ill) e = '0;
    e.pc  = pc;
    e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 13);
    if (sel < 11) begin
      r[6:0] = opc_tab[sel];
      if ($urandom_range(0, 2) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'd32 : 7'd0;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the FIFO model, then compare after the edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    bit   acc, con;
    exp_t popped;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    acc = v && (q.size() < 2) && !fl;
    con = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (con) begin popped = q.pop_front(); seen.push_back(popped.pc); end
      if (acc) q.push_back(ref_decode(inst, pc));
    end
    #1;
    check("out_valid", 96'(out_valid), 96'(q.size() > 0));
    check("in_ready", 96'(in_ready), 96'(q.size() < 2));
    if (q.size() > 0)
      check("payload", 96'({out_pc, imm, inst_type, funct, rd, rs1, rs2, illegal}), 96'(q[0]));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 96'(out_valid), 96'(0));
    check("rst_in_ready", 96'(in_ready), 96'(1));
    check("rst_data", 96'({out_pc, imm, inst_type, funct, rd, rs1, rs2, illegal}), 96'(0));

    step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
    check("addi_type", 96'(inst_type), 96'(T_IMM));
    check("addi_fn", 96'(funct), 96'(F_ADD));
    check("addi_fields", 96'({rd, rs1, imm, illegal}), 96'({5'd1, 5'd0, 32'd5, 1'b0}));

    step(1'b1, 32'h402081B3, 32'h104, 1'b1, 1'b0);
    check("sub", 96'({inst_type, funct, rd, rs1, rs2}), 96'({T_REG, F_SUB, 5'd3, 5'd1, 5'd2}));
    step(1'b1, 32'h40335293, 32'h108, 1'b1, 1'b0);
    check("srai", 96'({inst_type, funct, rd, rs1, imm}), 96'({T_IMM, F_SRA, 5'd5, 5'd6, 32'd3}));
    step(1'b1, 32'h0020A423, 32'h10C, 1'b1, 1'b0);
    check("sw", 96'({inst_type, funct, imm, rs1, rs2, rd}),
          96'({T_STORE, F_MW, 32'd8, 5'd1, 5'd2, 5'd0}));
    step(1'b1, 32'hFE208EE3, 32'h110, 1'b1, 1'b0);
    check("beq", 96'({inst_type, funct, imm}), 96'({T_BRANCH, F_EQ, 32'hFFFFFFFC}));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Output stall with three instructions offered
    seen.delete();
    step(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00200193, 32'h204, 1'b0, 1'b0);
    check("stall_in_ready", 96'(in_ready), 96'(0));
    step(1'b1, 32'h00300213, 32'h208, 1'b0, 1'b0);
    check("stall_hold_pc", 96'(out_pc), 96'(32'h200));
    step(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0);
    step(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("stall_order", 96'({seen.size(), seen[0], seen[1], seen[2]}),
          96'({32'd3, 32'h200, 32'h204, 32'h208}));

    step(1'b1, 32'h00000000, 32'h300, 1'b1, 1'b0);
    check("ill_zero", 96'({illegal, inst_type, funct, out_valid, out_pc}),
          96'({1'b1, 4'd0, 5'd0, 1'b1, 32'h300}));
    step(1'b1, 32'h0020C423, 32'h304, 1'b1, 1'b0);
    check("ill_store", 96'({illegal, inst_type, imm, rs1, rs2, out_pc}),
          96'({1'b1, 4'd0, 32'd0, 5'd0, 5'd0, 32'h304}));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with both entries held and a new instruction offered
    seen.delete();
    step(1'b1, 32'h00100113, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h00200193, 32'h404, 1'b0, 1'b0);
    step(1'b1, 32'h00300213, 32'h408, 1'b0, 1'b1);
    check("flush_out_valid", 96'(out_valid), 96'(0));
    check("flush_in_ready", 96'(in_ready), 96'(1));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("flush_none_seen", 96'(seen.size()), 96'(0));

    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFFFFFC,
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
